// File: rtl/pa_dst_writer_if.sv
// Bus bundle for the destination writer: result-word handshake from the
// processing array plus the request/grant memory write port.
interface pa_dst_writer_if #(
  parameter int ADDR_W = 16
);
  logic              in_rdy;
  logic              in_acq;
  logic [31:0]       in_data;
  logic              mem_wr_req;
  logic              mem_wr_gnt;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_wr_be;

  // Writer side: consumes result words, drives memory writes.
  modport slave (
    input  in_rdy, in_data, mem_wr_gnt,
    output in_acq, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be
  );

  // Environment side: supplies result words, grants memory writes.
  modport master (
    output in_rdy, in_data, mem_wr_gnt,
    input  in_acq, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be
  );
endinterface

// File: rtl/pa_dst_writer.sv
// Output write-back stage: buffers packed 4x8-bit result words in a small
// FIFO and writes them row-major to memory with per-row tail byte enables.
module pa_dst_writer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [31:0]          lhs_rows,
  input  logic [31:0]          rhs_rows,
  pa_dst_writer_if.slave       bus,
  output logic                 busy,
  output logic                 done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_ofs_q;
  logic [31:0]       wpr_q, total_q, acc_cnt_q, wr_cnt_q, col_q;
  logic [1:0]        rem_q;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;

  logic        fifo_empty, fifo_full, push, pop, last_col, zero_dims;
  logic [31:0] wpr_in, total_in;
  logic [3:0]  tail_be;

  assign wpr_in    = (rhs_rows + 32'd3) >> 2;
  assign total_in  = lhs_rows * wpr_in;
  assign zero_dims = (lhs_rows == 32'd0) || (rhs_rows == 32'd0);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign bus.in_acq = (state_q == RUN) && !fifo_full && (acc_cnt_q < total_q);
  assign push       = bus.in_rdy && bus.in_acq;
  assign pop        = bus.mem_wr_req && bus.mem_wr_gnt;

  assign last_col = (col_q == wpr_q - 32'd1);

  // Tail byte-enable for the last word of a row when channels are not a multiple of 4.
  always_comb begin
    tail_be = 4'hF;
    case (rem_q)
      2'd1:    tail_be = 4'h1;
      2'd2:    tail_be = 4'h3;
      2'd3:    tail_be = 4'h7;
      default: tail_be = 4'hF;
    endcase
  end

  // The running offset equals row*wpr + col because col never exceeds wpr-1,
  // so a single incrementer replaces the multiply; outputs idle at zero.
  assign bus.mem_wr_req  = !fifo_empty;
  assign bus.mem_wr_addr = fifo_empty ? '0 : (base_q + addr_ofs_q);
  assign bus.mem_wr_data = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.mem_wr_be   = fifo_empty ? 4'h0 : (last_col ? tail_be : 4'hF);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: the jump to DONE is taken on the edge of the last write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = zero_dims ? DONE : RUN;
      end
      RUN, DRAIN: begin
        if ((acc_cnt_q == total_q) &&
            ((wr_cnt_q == total_q) || (pop && (wr_cnt_q + 32'd1 == total_q))))
          state_d = DONE;
        else if ((state_q == RUN) && (acc_cnt_q == total_q))
          state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job configuration, latched only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      wpr_q   <= 32'd0;
      total_q <= 32'd0;
      rem_q   <= 2'd0;
    end else if ((state_q == IDLE) && start) begin
      base_q  <= base_addr;
      wpr_q   <= wpr_in;
      total_q <= total_in;
      rem_q   <= rhs_rows[1:0];
    end
  end

  // Accepted/written counters and the row-position tracking for addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q  <= 32'd0;
      wr_cnt_q   <= 32'd0;
      col_q      <= 32'd0;
      addr_ofs_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      acc_cnt_q  <= 32'd0;
      wr_cnt_q   <= 32'd0;
      col_q      <= 32'd0;
      addr_ofs_q <= '0;
    end else begin
      if (push) acc_cnt_q <= acc_cnt_q + 32'd1;
      if (pop) begin
        wr_cnt_q   <= wr_cnt_q + 32'd1;
        addr_ofs_q <= addr_ofs_q + 1'b1;
        col_q      <= last_col ? 32'd0 : col_q + 32'd1;
      end
    end
  end

  // FIFO pointers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_data;
  end

endmodule

// File: tb/tb_pa_dst_writer.sv
// Self-checking bench for pa_dst_writer: expected writes are queued as words
// are accepted and compared as the memory port issues them.
module tb_pa_dst_writer;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [31:0] lhs_rows = '0, rhs_rows = '0;
  logic        busy, done;

  pa_dst_writer_if #(.ADDR_W(ADDR_W)) bus ();

  pa_dst_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .lhs_rows(lhs_rows), .rhs_rows(rhs_rows), .bus(bus.slave),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  sb_t         sb_q[$];
  sb_t         exp_e, obs_e;
  logic [15:0] m_base;
  logic [31:0] m_wpr, m_total;
  logic [1:0]  m_rem;
  int unsigned acc_k;
  logic [31:0] src_word;

  logic obs_push, obs_pop, obs_acq, obs_req, obs_done, obs_busy;

  // Reference placement of the k-th word: row-major with tail byte enables.
  function automatic sb_t model(input int unsigned k, input logic [31:0] d);
    sb_t e;
    logic [31:0] row, col, a;
    row = k / m_wpr;
    col = k % m_wpr;
    a = 32'(m_base) + row * m_wpr + col;
    e.addr = a[15:0];
    e.data = d;
    e.be = 4'hF;
    if (col == m_wpr - 1) begin
      case (m_rem)
        2'd1: e.be = 4'h1;
        2'd2: e.be = 4'h3;
        2'd3: e.be = 4'h7;
        default: e.be = 4'hF;
      endcase
    end
    return e;
  endfunction

  task automatic configure(input logic [15:0] b, input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] first_word);
    @(negedge clk);
    base_addr = b; lhs_rows = l; rhs_rows = r;
    m_base = b; m_wpr = (r + 32'd3) >> 2; m_total = l * m_wpr; m_rem = r[1:0];
    acc_k = 0; src_word = first_word;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, queue expectations.
  task automatic step(input logic rdy, input logic gnt, input logic st);
    @(negedge clk);
    start = st; bus.in_rdy = rdy; bus.in_data = src_word; bus.mem_wr_gnt = gnt;
    #1;
    obs_acq  = bus.in_acq;
    obs_req  = bus.mem_wr_req;
    obs_push = rdy && bus.in_acq;
    obs_pop  = bus.mem_wr_req && gnt;
    obs_e    = '{addr: bus.mem_wr_addr, data: bus.mem_wr_data, be: bus.mem_wr_be};
    obs_done = done;
    obs_busy = busy;
    if (obs_push) begin
      sb_q.push_back(model(acc_k, src_word));
      acc_k++;
      src_word++;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_rdy = 1'b0; bus.in_data = '0; bus.mem_wr_gnt = 1'b0;
    #3;
    tests_run++;
    if ({bus.in_acq, bus.mem_wr_req, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl got=%b want=0000", {bus.in_acq, bus.mem_wr_req, busy, done});
    end
    tests_run++;
    if ({bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_be} !== 52'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus got=%h want=0", {bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_be});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int writes = 0, last_pop = -1, done_cyc = -1;
    configure(16'h0100, 32'd2, 32'd8, 32'hA0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({obs_acq, obs_req} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_run acq,req got=%b want=10", {obs_acq, obs_req});
    end
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_pop) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("[TB] FAIL basic_sb unexpected write got=%h", obs_e);
        end else begin
          exp_e = sb_q.pop_front();
          if (obs_e !== exp_e) begin
            tests_failed++; $display("[TB] FAIL basic_sb got=%h want=%h", obs_e, exp_e);
          end
        end
        writes++; last_pop = c;
      end
      if (obs_done) done_cyc = c;
    end
    tests_run++;
    if (writes != 4 || acc_k != 4) begin
      tests_failed++; $display("[TB] FAIL basic_count writes=%0d acc=%0d want 4/4", writes, acc_k);
    end
    tests_run++;
    if (done_cyc != last_pop + 1 || done_cyc < 0) begin
      tests_failed++; $display("[TB] FAIL basic_done_time got=%0d want=%0d", done_cyc, last_pop + 1);
    end
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({obs_busy, obs_done, obs_acq} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL basic_after_done busy,done,acq got=%b want=000", {obs_busy, obs_done, obs_acq});
    end
  endtask

  task automatic test_tail_be();
    logic [3:0] be_seq [6] = '{4'hF, 4'h3, 4'hF, 4'h3, 4'hF, 4'h3};
    int writes = 0, done_cyc = -1;
    configure(16'h0010, 32'd3, 32'd6, 32'h1000);
    step(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_pop) begin
        tests_run++;
        if (sb_q.size() == 0 || writes >= 6) begin
          tests_failed++; $display("[TB] FAIL tail_sb unexpected write got=%h", obs_e);
        end else begin
          exp_e = sb_q.pop_front();
          if (obs_e !== exp_e || obs_e.be !== be_seq[writes] || obs_e.addr !== 16'h0010 + 16'(writes)) begin
            tests_failed++; $display("[TB] FAIL tail_sb got=%h want=%h be=%h", obs_e, exp_e, be_seq[writes]);
          end
        end
        writes++;
      end
      if (obs_done) done_cyc = c;
    end
    tests_run++;
    if (writes != 6 || done_cyc < 0) begin
      tests_failed++; $display("[TB] FAIL tail_count writes=%0d done_seen=%0d want 6/1", writes, done_cyc >= 0);
    end
  endtask

  task automatic test_backpressure();
    int pushes = 0, writes = 0, last_pop = -1, done_cyc = -1;
    logic seen_req = 1'b0, stall_bad = 1'b0;
    sb_t  held;
    configure(16'h0000, 32'd2, 32'd16, 32'h2000);
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (obs_push) pushes++;
      if (seen_req && (!obs_req || obs_e !== held)) stall_bad = 1'b1;
      if (obs_req && !seen_req) begin seen_req = 1'b1; held = obs_e; end
    end
    tests_run++;
    if (pushes != DEPTH || obs_acq !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bp_accepts got=%0d acq=%b want=%0d acq=0", pushes, obs_acq, DEPTH);
    end
    tests_run++;
    if (!seen_req || stall_bad || held.addr !== 16'h0000 || held.data !== 32'h2000) begin
      tests_failed++; $display("[TB] FAIL bp_stable seen=%b unstable=%b held=%h want addr 0000 data 00002000", seen_req, stall_bad, held);
    end
    for (int c = 0; c < 80 && done_cyc < 0; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_pop) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("[TB] FAIL bp_sb unexpected write got=%h", obs_e);
        end else begin
          exp_e = sb_q.pop_front();
          if (obs_e !== exp_e) begin
            tests_failed++; $display("[TB] FAIL bp_sb got=%h want=%h", obs_e, exp_e);
          end
        end
        writes++; last_pop = c;
      end
      if (obs_done) done_cyc = c;
    end
    tests_run++;
    if (writes != 8 || done_cyc != last_pop + 1 || done_cyc < 0) begin
      tests_failed++; $display("[TB] FAIL bp_drain writes=%0d done=%0d lastpop=%0d want 8 writes", writes, done_cyc, last_pop);
    end
  endtask

  task automatic test_zero_dims();
    int reqs = 0, dones = 0;
    configure(16'h0040, 32'd0, 32'd16, 32'h3000);
    step(1'b1, 1'b1, 1'b1);
    #1;
    lhs_rows = 32'd1; rhs_rows = 32'd4; base_addr = 16'h0500;
    step(1'b1, 1'b1, 1'b1);
    tests_run++;
    if ({obs_done, obs_busy, obs_req} !== 3'b110) begin
      tests_failed++; $display("[TB] FAIL zero_done done,busy,req got=%b want=110", {obs_done, obs_busy, obs_req});
    end
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_req || obs_acq || obs_busy) reqs++;
      if (obs_done) dones++;
    end
    tests_run++;
    if (reqs != 0 || dones != 0) begin
      tests_failed++; $display("[TB] FAIL zero_ignored_start activity=%0d dones=%0d want 0/0", reqs, dones);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wrap_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    int writes = 0, done_cyc = -1;
    configure(16'hFFFE, 32'd1, 32'd16, 32'h4000);
    step(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_pop) begin
        tests_run++;
        if (sb_q.size() == 0 || writes >= 4) begin
          tests_failed++; $display("[TB] FAIL wrap_sb unexpected write got=%h", obs_e);
        end else begin
          exp_e = sb_q.pop_front();
          if (obs_e !== exp_e || obs_e.addr !== wrap_addr[writes]) begin
            tests_failed++; $display("[TB] FAIL wrap_sb got=%h want=%h", obs_e, exp_e);
          end
        end
        writes++;
      end
      if (obs_done) done_cyc = c;
    end
    tests_run++;
    if (writes != 4 || done_cyc < 0) begin
      tests_failed++; $display("[TB] FAIL wrap_count writes=%0d want=4", writes);
    end
  endtask

  task automatic test_reset_midjob();
    int writes = 0, done_cyc = -1;
    configure(16'h0200, 32'd2, 32'd16, 32'h5000);
    step(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 30 && writes < 2; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_pop) begin
        tests_run++;
        exp_e = sb_q.pop_front();
        if (obs_e !== exp_e) begin
          tests_failed++; $display("[TB] FAIL midrst_pre got=%h want=%h", obs_e, exp_e);
        end
        writes++;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_acq, bus.mem_wr_req, busy, done, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_be} !== 56'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_async got=%h want=0",
               {bus.in_acq, bus.mem_wr_req, busy, done, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_be});
    end
    @(negedge clk);
    rst_n = 1'b1;
    writes = 0;
    configure(16'h0300, 32'd1, 32'd4, 32'h55);
    step(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 30 && done_cyc < 0; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (obs_pop) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("[TB] FAIL midrst_sb stale write got=%h", obs_e);
        end else begin
          exp_e = sb_q.pop_front();
          if (obs_e !== exp_e || obs_e !== {16'h0300, 32'h55, 4'hF}) begin
            tests_failed++; $display("[TB] FAIL midrst_sb got=%h want=%h", obs_e, exp_e);
          end
        end
        writes++;
      end
      if (obs_done) done_cyc = c;
    end
    tests_run++;
    if (writes != 1 || done_cyc < 0) begin
      tests_failed++; $display("[TB] FAIL midrst_count writes=%0d want=1", writes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail_be();
    test_backpressure();
    test_zero_dims();
    test_wrap();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pa_dst_writer.md
# pa_dst_writer

Output write-back stage that sits directly downstream of the processing-array top. It accepts packed 4×8-bit quantized result words through the array's destination-write handshake and buffers them in a small FIFO. It generates row-major destination addresses with per-row tail byte-enables, and issues one memory write per word over a request/grant port. A `done` pulse marks the end of the output matrix.

## Interface
Parameters:
- `ADDR_W`, 16: width of the memory word address.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; latches the configuration and begins a job.
- `base_addr`  in  ADDR_W  destination word address of row 0, word 0.
- `lhs_rows`  in  32  number of output rows.
- `rhs_rows`  in  32  output channels per row; each input word carries 4 channels.
- `in_rdy`  in  1  source has a valid result word (array `write_rdy`).
- `in_acq`  out  1  this block accepts the word (array `write_acq`).
- `in_data`  in  32  result word; byte k is channel 4·w+k.
- `mem_wr_req`  out  1  write request.
- `mem_wr_gnt`  in  1  memory accepts the write this cycle.
- `mem_wr_addr`  out  ADDR_W  word address.
- `mem_wr_data`  out  32  write data.
- `mem_wr_be`  out  4  byte enables.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Derived values, latched on `start`:
  - `wpr` = (rhs_rows+3)>>2 (32-bit).
  - `total` = lhs_rows·wpr, truncated to 32 bits.
  - `rem` = rhs_rows[1:0].
- Input transfer: occurs when `in_rdy && in_acq` in the same cycle.
  - `in_acq` = (state==RUN) && FIFO not full && accepted-count < total.
  - `in_acq` is combinational from registered state only; it never depends on `in_rdy`.
- FIFO: push on an input transfer, pop on a memory transfer (`mem_wr_req && mem_wr_gnt`).
  - Simultaneous push and pop is allowed when not full; occupancy is unchanged.
  - When full, the push is blocked by `in_acq`=0, even if a pop occurs in the same cycle.
- Memory side:
  - `mem_wr_req` = FIFO not empty.
  - `mem_wr_data` = FIFO head.
  - `mem_wr_addr`/`mem_wr_data`/`mem_wr_be` stay stable while `mem_wr_req`=1 and `mem_wr_gnt`=0.
- Address generation:
  - Counters `row` and `col` advance on each memory transfer.
  - `mem_wr_addr` = base_addr + row·wpr + col, computed modulo 2^ADDR_W (wraps silently).
  - `col` wraps to 0 at wpr−1 and increments `row`.
- Byte enables:
  - `mem_wr_be` = 4'hF, except when col==wpr−1 and rem≠0.
  - In that case `mem_wr_be` = 4'h1 for rem=1, 4'h3 for rem=2, 4'h7 for rem=3.
- States:
  - IDLE: `start` → RUN; if lhs_rows==0 or rhs_rows==0 → DONE, with no writes.
  - RUN: when accepted-count reaches total → DRAIN.
  - DRAIN: when the FIFO is empty and written-count==total → DONE.
  - DONE: pulses `done` for one cycle → IDLE.
- `busy` = 1 in RUN, DRAIN and DONE.
- `start` while `busy` is ignored; the configuration is not re-latched.
- Input words offered after total is reached are not accepted (`in_acq` stays 0).

## Timing
- Reset values:
  - `in_acq`=0, `mem_wr_req`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `mem_wr_be`=0.
  - `busy`=0, `done`=0.
  - FIFO empty, counters 0, state IDLE.
- Start to acceptance: `start` sampled at edge N → state RUN and `in_acq` may be 1 in cycle N+1.
- Input to memory latency: a word accepted at edge M is presented on `mem_wr_req` from cycle M+1 at the earliest (registered FIFO, no bypass).
- Throughput: one word per cycle when `mem_wr_gnt` is held at 1.
- `done` asserts in the cycle after the edge on which the last memory transfer completes; `busy` falls in the following cycle.
- Zero dimensions: `start` at edge N → `done`=1 in cycle N+1, and no `mem_wr_req` is issued.
- Reset mid-job:
  - All outputs return to their reset values asynchronously.
  - FIFO contents are discarded and no further writes are issued.
- Back-pressure: with `mem_wr_gnt`=0 and the source always ready, exactly FIFO_DEPTH words are accepted, then `in_acq`=0.

## Test plan
- lhs_rows=2, rhs_rows=8, base_addr=0x0100, gnt always 1, source streams words 0xA0..0xA3 → writes to 0x100..0x103 with be=F, data in order; `done` 1 cycle after the last grant.
- lhs_rows=3, rhs_rows=6 (wpr=2, rem=2), base_addr=0x0010 → addrs 0x10..0x15; be sequence F,3,F,3,F,3.
- gnt=0 for 20 cycles, source always ready, FIFO_DEPTH=4 → exactly 4 acceptances, `mem_wr_req` held with stable addr 0x0; then gnt=1 → remaining words drain in order.
- lhs_rows=0, rhs_rows=16, `start` → `done` next cycle, zero `mem_wr_req`; a second `start` pulsed while `busy` is ignored.
- base_addr=0xFFFE, lhs_rows=1, rhs_rows=16 → addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
- rst_n low after 2 of 8 words written, then `start` with new config lhs_rows=1, rhs_rows=4 → only 1 write at base_addr, be=F; no stale FIFO data appears.
